// File: rtl/timer_cmd_sender.sv
// -----------------------------------------------------------------------------
// timer_cmd_sender
//
// Purpose:
//    Initiator side of the serial timer-command protocol. A 4-bit delay
//    request is accepted over a valid/ready handshake and shadowed. The block
//    then drives GAP_CYCLES guard zeros, the start pattern 1101 and the delay
//    code MSB first on the registered serial line `data`. It then waits for the
//    timer's `done`, answers it with a one-cycle `ack`, and reports completion
//    to the requester. If `done` never arrives, a watchdog reports a timeout.
//
// Parameters:
//    GAP_CYCLES      guard zero cycles before each start pattern (>= 1)
//    TIMEOUT_CYCLES  WAIT_DONE cycles before a timeout is declared (>= 2)
//
// Ports:
//    clk           system clock, all state on the rising edge
//    reset_n       asynchronous active-low reset
//    req_valid     request present
//    req_ready     request can be accepted (high only in IDLE)
//    req_delay     delay code, captured on acceptance
//    data          registered serial line to the timer
//    done          timer expired, held high by the timer until ack
//    ack           registered one-cycle acknowledge to the timer
//    busy          high whenever the FSM is not IDLE
//    resp_valid    one-cycle completion pulse
//    resp_timeout  qualifies resp_valid: 1 = watchdog expired, 0 = normal done
// -----------------------------------------------------------------------------
module timer_cmd_sender #(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_delay,
   output logic       data,
   input  logic       done,
   output logic       ack,
   output logic       busy,
   output logic       resp_valid,
   output logic       resp_timeout
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    START_PAT = 4'b1101;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      SEND_PAT,
      SEND_DLY,
      WAIT_DONE,
      ACK
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [1:0]      bit_q, bit_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [3:0]      delay_q, delay_d;
   logic            data_q, data_d;
   logic            ack_q, ack_d;
   logic            rv_q, rv_d;
   logic            rt_q, rt_d;

   // State and registered outputs. Reset is asynchronous so the serial line,
   // ack and the response pulse drop immediately, even mid-transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gap_q   <= '0;
         bit_q   <= '0;
         wd_q    <= '0;
         delay_q <= '0;
         data_q  <= 1'b0;
         ack_q   <= 1'b0;
         rv_q    <= 1'b0;
         rt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         wd_q    <= wd_d;
         delay_q <= delay_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         rv_q    <= rv_d;
         rt_q    <= rt_d;
      end
   end

   // Next-state logic. The registered outputs are computed from the *next*
   // state so that they line up with the state they belong to, giving a
   // bubble-free serial stream with one bit per cycle.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      bit_d   = bit_q;
      wd_d    = wd_q;
      delay_d = delay_q;
      data_d  = 1'b0;
      ack_d   = 1'b0;
      rv_d    = 1'b0;
      rt_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = GAP;
               delay_d = req_delay;
               gap_d   = '0;
            end
         end

         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = SEND_PAT;
               bit_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         SEND_PAT: begin
            if (bit_q == 2'd3) begin
               state_d = SEND_DLY;
               bit_d   = '0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end

         SEND_DLY: begin
            if (bit_q == 2'd3) begin
               state_d = WAIT_DONE;
               wd_d    = '0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end

         // done takes priority over the watchdog terminal count
         WAIT_DONE: begin
            if (done) begin
               state_d = ACK;
            end else if (wd_q == WD_LAST) begin
               state_d = IDLE;
               rv_d    = 1'b1;
               rt_d    = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         ACK: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Serial bit for the upcoming cycle, both fields sent MSB first
      case (state_d)
         SEND_PAT: data_d = START_PAT[2'd3 - bit_d];
         SEND_DLY: data_d = delay_d[2'd3 - bit_d];
         default:  data_d = 1'b0;
      endcase

      if (state_d == ACK) begin
         ack_d = 1'b1;
         rv_d  = 1'b1;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign data         = data_q;
   assign ack          = ack_q;
   assign resp_valid   = rv_q;
   assign resp_timeout = rt_q;

endmodule

// File: tb/tb_timer_cmd_sender.sv
// -----------------------------------------------------------------------------
// tb_timer_cmd_sender
//
// Scoreboard bench for timer_cmd_sender (GAP_CYCLES=2, TIMEOUT_CYCLES=20000).
// Stimulus pushes the expected serial stream and the expected response for
// each request. A negedge monitor pops a stream on every acceptance and a
// response on every resp_valid/ack, and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_timer_cmd_sender;

   localparam int GAP = 2;
   localparam int TO  = 20000;

   typedef struct {
      logic timeout;
      int   lat;
   } resp_t;

   logic       clk;
   logic       reset_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_delay;
   logic       data;
   logic       done;
   logic       ack;
   logic       busy;
   logic       resp_valid;
   logic       resp_timeout;

   int vecCount  = 0;
   int missCount = 0;

   logic [10:0] streamQ[$];
   resp_t       respQ[$];

   timer_cmd_sender #(
      .GAP_CYCLES    (GAP),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_delay   (req_delay),
      .data        (data),
      .done        (done),
      .ack         (ack),
      .busy        (busy),
      .resp_valid  (resp_valid),
      .resp_timeout(resp_timeout)
   );

   // Free-running clock: rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point shared by the monitor and the stimulus
   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual != expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Expected line contents for intervals 0..10 after acceptance, bit n = interval n
   function automatic logic [10:0] streamFor(input logic [3:0] d);
      logic [10:0] s;
      s     = '0;
      s[2]  = 1'b1;
      s[3]  = 1'b1;
      s[4]  = 1'b0;
      s[5]  = 1'b1;
      s[6]  = d[3];
      s[7]  = d[2];
      s[8]  = d[1];
      s[9]  = d[0];
      s[10] = 1'b0;
      return s;
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge
   int          ncyc = 0;
   int          accCyc = 0;
   int          lastAcc = 0;
   logic        streamActive = 1'b0;
   logic [10:0] curStream = '0;
   int          nIdx;
   resp_t       r;

   always @(negedge clk) begin
      ncyc++;
      if (!reset_n) begin
         streamActive = 1'b0;
      end else begin
         if (streamActive) begin
            nIdx = ncyc - accCyc - 1;
            if (nIdx <= 10) begin
               checkOutput($sformatf("data_n%0d", nIdx), int'(data), int'(curStream[nIdx]));
            end
            if (nIdx >= 10) begin
               streamActive = 1'b0;
            end
         end
         if (resp_valid || ack) begin
            if (respQ.size() == 0) begin
               checkOutput("unexpected_response", 1, 0);
            end else begin
               r = respQ.pop_front();
               checkOutput("resp_valid", int'(resp_valid), 1);
               checkOutput("resp_timeout", int'(resp_timeout), int'(r.timeout));
               checkOutput("ack", int'(ack), int'(!r.timeout));
               checkOutput("resp_latency", ncyc - lastAcc - 1, r.lat);
            end
         end else if (resp_timeout) begin
            checkOutput("timeout_without_valid", int'(resp_timeout), 0);
         end
         if (req_valid && req_ready) begin
            if (streamQ.size() == 0) begin
               checkOutput("unexpected_accept", 1, 0);
            end else begin
               curStream    = streamQ.pop_front();
               streamActive = 1'b1;
               accCyc       = ncyc;
               lastAcc      = ncyc;
            end
         end
      end
   end

   // Waits for acceptance; returns 1 time unit into interval 0
   task automatic waitAccept(output int waited);
      waited = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_valid && req_ready) begin
            waited = i;
            break;
         end
      end
      if (waited < 0) begin
         checkOutput("accept_wait_expired", 0, 1);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitResp();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < TO + 200; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checkOutput("resp_wait_expired", 0, 1);
      end
   endtask

   // One complete request. doneAt < 0 means the timer never answers;
   // strayAt >= 0 adds a one-cycle done pulse at that interval.
   task automatic applyStimulus(input logic [3:0] dly, input int doneAt, input int strayAt,
                                input logic expTo, input int expLat, input logic [3:0] dlyAfter);
      int    waited;
      int    cur;
      resp_t e;
      e.timeout = expTo;
      e.lat     = expLat;
      streamQ.push_back(streamFor(dly));
      respQ.push_back(e);
      req_valid = 1'b1;
      req_delay = dly;
      waitAccept(waited);
      req_valid = 1'b0;
      req_delay = dlyAfter;
      cur = 0;
      if (strayAt >= 0) begin
         repeat (strayAt) @(posedge clk);
         #1;
         done = 1'b1;
         @(posedge clk);
         #1;
         done = 1'b0;
         cur = strayAt + 1;
      end
      if (doneAt >= 0) begin
         repeat (doneAt - cur) @(posedge clk);
         #1;
         done = 1'b1;
      end
      waitResp();
      @(posedge clk);
      #1;
      done = 1'b0;
   endtask

   // Global guard so the run can never hang
   initial begin
      #950000;
      $display("[TB] FAIL global_timeout: got 0, expected 1");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int    waited;
      resp_t e;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_delay = 4'b0000;
      done      = 1'b0;

      // Reset defaults before any clock edge
      #3;
      checkOutput("rst_req_ready", int'(req_ready), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_data", int'(data), 0);
      checkOutput("rst_ack", int'(ack), 0);
      checkOutput("rst_resp_valid", int'(resp_valid), 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] normal command 1010");
      applyStimulus(4'b1010, 40, -1, 1'b0, 41, 4'b0101);

      $display("[TB] delay corner codes");
      applyStimulus(4'b0000, 1010, -1, 1'b0, 1011, 4'b1111);
      applyStimulus(4'b1111, 16010, -1, 1'b0, 16011, 4'b0000);

      $display("[TB] watchdog timeout");
      applyStimulus(4'b0110, -1, -1, 1'b1, 10 + TO, 4'b0000);

      $display("[TB] done on the watchdog terminal cycle");
      applyStimulus(4'b1001, 10 + TO - 1, -1, 1'b0, 10 + TO, 4'b0000);

      $display("[TB] stray done during start pattern");
      applyStimulus(4'b0011, 15, 3, 1'b0, 16, 4'b0000);

      $display("[TB] back-to-back with held valid");
      streamQ.push_back(streamFor(4'b0101));
      streamQ.push_back(streamFor(4'b1100));
      e.timeout = 1'b0;
      e.lat     = 16;
      respQ.push_back(e);
      e.lat     = 21;
      respQ.push_back(e);
      req_valid = 1'b1;
      req_delay = 4'b0101;
      waitAccept(waited);
      req_delay = 4'b1100;
      repeat (15) @(posedge clk);
      #1;
      done = 1'b1;
      waitResp();
      @(posedge clk);
      #1;
      done = 1'b0;
      waitAccept(waited);
      checkOutput("b2b_accept_gap", waited, 0);
      req_valid = 1'b0;
      req_delay = 4'b0000;
      repeat (20) @(posedge clk);
      #1;
      done = 1'b1;
      waitResp();
      @(posedge clk);
      #1;
      done = 1'b0;

      $display("[TB] asynchronous reset during start pattern");
      streamQ.push_back(streamFor(4'b1111));
      req_valid = 1'b1;
      req_delay = 4'b1111;
      waitAccept(waited);
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pre_reset_data", int'(data), 1);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_data", int'(data), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_req_ready", int'(req_ready), 1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("[TB] asynchronous reset during ack");
      streamQ.push_back(streamFor(4'b0001));
      req_valid = 1'b1;
      req_delay = 4'b0001;
      waitAccept(waited);
      req_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      done = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("pre_reset_ack", int'(ack), 1);
      checkOutput("pre_reset_resp_valid", int'(resp_valid), 1);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("ackrst_ack", int'(ack), 0);
      checkOutput("ackrst_resp_valid", int'(resp_valid), 0);
      checkOutput("ackrst_resp_timeout", int'(resp_timeout), 0);
      done = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("[TB] recovery, earliest done");
      applyStimulus(4'b0111, 10, -1, 1'b0, 11, 4'b1000);

      repeat (5) @(posedge clk);
      checkOutput("streams_left", streamQ.size(), 0);
      checkOutput("responses_left", respQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
